// File: rtl/muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared constants, types and a reference model for the RV32M multiply/divide
// unit.
//   - F3_* / F7_MULDIV : M-extension funct3/funct7 encodings
//   - muldiv_state_t   : FSM state encoding (IDLE, CALC, FIX, DONE)
//   - ST_* localparams : the same encodings as plain constants for RTL use
//   - muldiv_req_t     : one request (funct3, operands, destination tag)
//   - get_expected_muldiv : behavioural 32-bit reference result
// ---------------------------------------------------------------------------
package muldiv_unit_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam int MULDIV_XLEN = 32;
  localparam int MULDIV_RD_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  // Plain constants mirroring muldiv_state_t, used for the state register.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [2:0]             f3;
    logic [MULDIV_XLEN-1:0] a;
    logic [MULDIV_XLEN-1:0] b;
    logic [MULDIV_RD_W-1:0] rd;
  } muldiv_req_t;

  // Behavioural RV32M result, including the divide-by-zero and signed
  // overflow corner cases.
  function automatic logic [31:0] get_expected_muldiv(input logic [2:0]  f3,
                                                      input logic [31:0] a,
                                                      input logic [31:0] b);
    logic [63:0] sa;
    logic [63:0] ua;
    logic [63:0] sb;
    logic [63:0] ub;
    logic [63:0] p;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    ua  = {32'd0, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    get_expected_muldiv = 32'd0;
    case (f3)
      F3_MUL:    begin p = ua * ub; get_expected_muldiv = p[31:0];  end
      F3_MULH:   begin p = sa * sb; get_expected_muldiv = p[63:32]; end
      F3_MULHSU: begin p = sa * ub; get_expected_muldiv = p[63:32]; end
      F3_MULHU:  begin p = ua * ub; get_expected_muldiv = p[63:32]; end
      F3_DIV: begin
        if (b == 32'd0)  get_expected_muldiv = 32'hFFFF_FFFF;
        else if (ovf)    get_expected_muldiv = a;
        else             get_expected_muldiv = $signed(a) / $signed(b);
      end
      F3_DIVU: begin
        if (b == 32'd0)  get_expected_muldiv = 32'hFFFF_FFFF;
        else             get_expected_muldiv = a / b;
      end
      F3_REM: begin
        if (b == 32'd0)  get_expected_muldiv = a;
        else if (ovf)    get_expected_muldiv = 32'd0;
        else             get_expected_muldiv = $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'd0)  get_expected_muldiv = a;
        else             get_expected_muldiv = a % b;
      end
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if
// Request/response handshake bundle between the EX stage and muldiv_unit.
//   in_valid/in_ready : request handshake
//   in_f3             : M-extension funct3
//   in_a, in_b        : rs1/rs2 operands
//   in_rd             : destination tag, carried to out_rd
//   out_valid/out_ready : result handshake
//   out_result, out_rd  : result value and its tag
// master = requester/consumer (pipeline), slave = muldiv_unit.
// ---------------------------------------------------------------------------
interface muldiv_unit_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_f3;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [RD_W-1:0] in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [RD_W-1:0] out_rd;

  modport master (
    output in_valid, in_f3, in_a, in_b, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd
  );

  modport slave (
    input  in_valid, in_f3, in_a, in_b, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd
  );

endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. Multiplies with a radix-2 shift-add
// and divides with a restoring divider, one bit per cycle for XLEN cycles,
// on operand magnitudes; the sign is applied in a single fix-up cycle.
// Divide-by-zero and signed overflow bypass the datapath and complete in one
// cycle.
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset (priority over flush)
//   flush     : kills any in-flight operation, returns to IDLE
//   stall_req : hold ID/EX while busy or while a result is back-pressured
//   bus       : muldiv_unit_if slave (request in, result out)
// ---------------------------------------------------------------------------
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  output logic          stall_req,
  muldiv_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   opB_q, opB_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [RD_W-1:0]   rd_q, rd_d;

  // Request decode: signedness, magnitudes and the one-cycle special cases.
  logic            isDiv, isRem, aSigned, bSigned, aNeg, bNeg;
  logic            bZero, divOvf, special;
  logic [XLEN-1:0] absA, absB, specialRes;

  always_comb begin
    isDiv   = bus.in_f3[2];
    isRem   = bus.in_f3[2] & bus.in_f3[1];
    aSigned = (bus.in_f3 == F3_MULH) | (bus.in_f3 == F3_MULHSU) |
              (bus.in_f3 == F3_DIV)  | (bus.in_f3 == F3_REM);
    bSigned = (bus.in_f3 == F3_MULH) | (bus.in_f3 == F3_DIV) |
              (bus.in_f3 == F3_REM);
    aNeg    = aSigned & bus.in_a[XLEN-1];
    bNeg    = bSigned & bus.in_b[XLEN-1];
    absA    = aNeg ? -bus.in_a : bus.in_a;
    absB    = bNeg ? -bus.in_b : bus.in_b;
    bZero   = (bus.in_b == '0);
    divOvf  = ((bus.in_f3 == F3_DIV) | (bus.in_f3 == F3_REM)) &
              (bus.in_a == {1'b1, {(XLEN-1){1'b0}}}) &
              (bus.in_b == '1);
    special = isDiv & (bZero | divOvf);
    // Divide by zero: quotient all-ones, remainder = dividend.
    // Signed overflow: quotient = dividend, remainder = 0.
    if (bZero) specialRes = isRem ? bus.in_a : '1;
    else       specialRes = isRem ? '0 : bus.in_a;
  end

  // One iteration of each algorithm. The accumulator holds the multiplier
  // (low half) under the growing partial product, or the dividend/quotient
  // (low half) under the partial remainder; both start as {0, |a|}.
  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] mulNext;
  logic [XLEN:0]     divShift;
  logic [XLEN+1:0]   divDiff;
  logic              divGe;
  logic [2*XLEN-1:0] divNext;

  always_comb begin
    mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               (acc_q[0] ? {1'b0, opB_q} : {(XLEN+1){1'b0}});
    mulNext  = {mulSum, acc_q[XLEN-1:1]};
    divShift = acc_q[2*XLEN-1:XLEN-1];
    divDiff  = {1'b0, divShift} - {2'b00, opB_q};
    divGe    = ~divDiff[XLEN+1];
    divNext  = {(divGe ? divDiff[XLEN-1:0] : divShift[XLEN-1:0]),
                acc_q[XLEN-2:0], divGe};
  end

  // Sign fix-up and result selection for the FIX cycle.
  logic [2*XLEN-1:0] prodFix;
  logic [XLEN-1:0]   quoFix, remFix, fixRes;

  always_comb begin
    prodFix = neg_q ? -acc_q : acc_q;
    quoFix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    remFix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (!f3_q[2])
      fixRes = (f3_q == F3_MUL) ? prodFix[XLEN-1:0] : prodFix[2*XLEN-1:XLEN];
    else
      fixRes = f3_q[1] ? remFix : quoFix;
  end

  // Next-state logic. Flush overrides everything and blocks acceptance, so a
  // request arriving alongside a flush is simply not taken.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opB_d    = opB_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    f3_d     = f3_q;
    result_d = result_q;
    rd_d     = rd_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            f3_d = bus.in_f3;
            rd_d = bus.in_rd;
            if (special) begin
              result_d = specialRes;
              state_d  = ST_DONE;
            end else begin
              acc_d   = {{XLEN{1'b0}}, absA};
              opB_d   = absB;
              neg_d   = isRem ? aNeg : (aNeg ^ bNeg);
              cnt_d   = '0;
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_d = f3_q[2] ? divNext : mulNext;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_FIX;
        end
        ST_FIX: begin
          result_d = fixRes;
          state_d  = ST_DONE;
        end
        default: begin
          if (bus.out_ready) state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers; reset wins over flush since it is checked first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      opB_q    <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      f3_q     <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opB_q    <= opB_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      f3_q     <= f3_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  // in_ready depends on state only; stall_req also looks at out_ready in DONE.
  always_comb begin
    bus.in_ready   = (state_q == ST_IDLE);
    bus.out_valid  = (state_q == ST_DONE);
    bus.out_result = result_q;
    bus.out_rd     = rd_q;
    stall_req      = (state_q == ST_CALC) | (state_q == ST_FIX) |
                     ((state_q == ST_DONE) & ~bus.out_ready);
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit (XLEN=32). Stimulus pushes hand-computed
// results into a queue; a monitor pops and compares on each accepted output.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic stall_req;

  muldiv_unit_if #(.XLEN(32), .RD_W(5)) bus ();

  muldiv_unit #(.XLEN(32), .RD_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall_req (stall_req),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [36:0] expQ [$];

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  // One comparison: count it, report it on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every accepted result must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    logic [36:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      checkOutput("result_expected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("out_result", bus.out_result, e[31:0]);
        checkOutput("out_rd", 32'(bus.out_rd), 32'(e[36:32]));
      end
    end
  end

  // Issue one request; returns one cycle after acceptance (cycle 1, +1).
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic [31:0] res, input bit push);
    int guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready) begin
      checkOutput("issue_in_ready", 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_f3    = f3;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_rd    = rd;
    if (push) expQ.push_back({rd, res});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_f3    = 3'($urandom);
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    bus.in_rd    = 5'($urandom);
  endtask

  // Count the cycle (relative to acceptance) in which out_valid first rises.
  task automatic waitResult(output int cycles, output bit stallOk);
    cycles  = 1;
    stallOk = 1'b1;
    while (!bus.out_valid && cycles < 200) begin
      if (!stall_req) stallOk = 1'b0;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t normVecs [9];
  vec_t specVecs [5];

  initial begin : stimulus
    int  cyc;
    bit  stallOk;
    bit  sawValid;

    normVecs[0] = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    normVecs[1] = '{F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    normVecs[2] = '{F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    normVecs[3] = '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    normVecs[4] = '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    normVecs[5] = '{F3_DIVU,   32'h0000_0007, 32'h0000_0002, 32'h0000_0003};
    normVecs[6] = '{F3_REMU,   32'h0000_0007, 32'h0000_0002, 32'h0000_0001};
    normVecs[7] = '{F3_DIV,    32'h8000_0000, 32'h0000_0002, 32'hC000_0000};
    normVecs[8] = '{F3_MULHSU, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};

    specVecs[0] = '{F3_DIV,  32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
    specVecs[1] = '{F3_REMU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
    specVecs[2] = '{F3_DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
    specVecs[3] = '{F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    specVecs[4] = '{F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_f3     = 3'd0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.in_rd     = 5'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready",   32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_valid",  32'(bus.out_valid), 32'd0);
    checkOutput("rst_stall_req",  32'(stall_req), 32'd0);
    checkOutput("rst_out_result", bus.out_result, 32'd0);
    checkOutput("rst_out_rd",     32'(bus.out_rd), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // MUL with latency and stall profile.
    applyStimulus(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 1'b1);
    waitResult(cyc, stallOk);
    checkOutput("mul_latency", 32'(cyc), 32'd34);
    checkOutput("mul_stall_1_33", 32'(stallOk), 32'd1);

    foreach (normVecs[i]) begin
      applyStimulus(normVecs[i].f3, normVecs[i].a, normVecs[i].b, 5'(i + 2),
                    normVecs[i].res, 1'b1);
      waitResult(cyc, stallOk);
      checkOutput("normal_latency", 32'(cyc), 32'd34);
    end

    foreach (specVecs[i]) begin
      applyStimulus(specVecs[i].f3, specVecs[i].a, specVecs[i].b, 5'(i + 16),
                    specVecs[i].res, 1'b1);
      waitResult(cyc, stallOk);
      checkOutput("special_latency", 32'(cyc), 32'd1);
    end
    @(posedge clk); #1;

    // Backpressure: result must hold while out_ready is low.
    bus.out_ready = 1'b0;
    applyStimulus(F3_DIVU, 32'd7, 32'd2, 5'd9, 32'd3, 1'b1);
    waitResult(cyc, stallOk);
    checkOutput("bp_latency", 32'(cyc), 32'd34);
    repeat (5) begin
      checkOutput("bp_out_valid",  32'(bus.out_valid), 32'd1);
      checkOutput("bp_out_result", bus.out_result, 32'd3);
      checkOutput("bp_out_rd",     32'(bus.out_rd), 32'd9);
      checkOutput("bp_stall_req",  32'(stall_req), 32'd1);
      checkOutput("bp_in_ready",   32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_idle", 32'(bus.in_ready), 32'd1);

    // Flush in cycle 10 of CALC; no result may appear.
    applyStimulus(F3_MUL, 32'h0000_1234, 32'h0000_5678, 5'd4, 32'd0, 1'b0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_in_ready",  32'(bus.in_ready), 32'd1);
    checkOutput("flush_stall_req", 32'(stall_req), 32'd0);
    checkOutput("flush_out_valid", 32'(bus.out_valid), 32'd0);
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkOutput("flush_no_result", 32'(sawValid), 32'd0);

    // A request coinciding with flush must not be accepted.
    bus.in_valid = 1'b1;
    bus.in_f3    = F3_MUL;
    bus.in_a     = 32'd1;
    bus.in_b     = 32'd1;
    bus.in_rd    = 5'd5;
    flush        = 1'b1;
    @(posedge clk); #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush_req_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("flush_req_stall",    32'(stall_req), 32'd0);

    applyStimulus(F3_MUL, 32'd3, 32'd4, 5'd3, 32'd12, 1'b1);
    waitResult(cyc, stallOk);
    checkOutput("post_flush_latency", 32'(cyc), 32'd34);
    @(posedge clk); #1;

    // Reset mid-operation.
    applyStimulus(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'd0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_in_ready",   32'(bus.in_ready), 32'd1);
    checkOutput("midrst_out_valid",  32'(bus.out_valid), 32'd0);
    checkOutput("midrst_stall_req",  32'(stall_req), 32'd0);
    checkOutput("midrst_out_result", bus.out_result, 32'd0);
    checkOutput("midrst_out_rd",     32'(bus.out_rd), 32'd0);
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkOutput("midrst_no_result", 32'(sawValid), 32'd0);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised RV32M multiply/divide unit for the EX stage. It takes two XLEN operands and an M-extension funct3 and returns the product (low or high half), quotient or remainder over a valid/ready handshake. While busy it drives a stall request so the pipeline holds the instruction in ID/EX. It extends the single-cycle ALU-result model with multi-cycle arithmetic, signed/unsigned mixed modes and RISC-V divide corner cases.

## Interface
- XLEN, 32, operand/result width; any even value ≥ 8
- RD_W, 5, destination-tag width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of any in-flight operation
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request (state IDLE)
- in_f3  in  3  M-extension funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- in_a, in_b  in  XLEN  rs1 and rs2 operands (post-forwarding)
- in_rd  in  RD_W  destination tag, carried through unchanged
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_result  out  XLEN  result
- out_rd  out  RD_W  tag of the result
- stall_req  out  1  high when state is CALC or FIX, or when state is DONE and out_ready is low

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE → CALC on in_valid & in_ready, for normal ops.
  - Latch |a| and |b| per signedness: MULH/DIV/REM treat a and b as signed; MULHSU treats a as signed and b as unsigned; MUL, MULHU, DIVU, REMU are unsigned.
  - Latch the result negate flag: a_sign ^ b_sign for products and quotients, a_sign for remainders.
  - Latch f3 and rd; clear the iteration counter.
- IDLE → DONE directly (special case) when:
  - Divide op with b == 0: DIV/DIVU → all-ones; REM/REMU → a.
  - DIV/REM with a == most-negative and b == −1: DIV → a; REM → 0.
- CALC: one iteration per cycle for exactly XLEN cycles.
  - Multiply: radix-2 shift-add into a 2·XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle; XLEN-bit quotient and XLEN-bit remainder.
  - CALC → FIX after iteration XLEN−1.
- FIX: conditional two's-complement negation.
  - Products negate the full 2·XLEN value.
  - MUL selects bits [XLEN−1:0]; MULH* select bits [2·XLEN−1:XLEN].
  - Result is registered into out_result; FIX → DONE.
- DONE: out_valid = 1. On out_ready → IDLE. out_result and out_rd stay stable while out_valid & !out_ready.
- No new request is accepted until the state returns to IDLE.
- in_a and in_b are sampled only at acceptance; later changes have no effect.
- flush: any state → IDLE at the next edge. No out_valid is produced for the killed op.
  - A request presented in the same cycle as flush is not accepted.
- rst takes priority over flush.
  - Reset values: state IDLE, in_ready 1, out_valid 0, stall_req 0, out_result 0, out_rd 0, counter 0.
- All arithmetic is modulo 2^XLEN (products 2^(2·XLEN)); there are no overflow flags.

## Timing
- The acceptance cycle is cycle 0.
- Normal op: CALC during cycles 1..XLEN, FIX at cycle XLEN+1, out_valid first high in cycle XLEN+2 (34 for XLEN=32).
- Special case: out_valid high in cycle 1.
- Minimum initiation interval: XLEN+3 cycles (normal op) or 2 cycles (special case), with out_ready held high.
- in_ready is combinational from state only; there is no combinational path from in_valid to in_ready.
- stall_req depends combinationally on out_ready in DONE.
- Reset mid-CALC: the unit is IDLE in the next cycle and out_valid stays 0.

## Structure
- Add to the shared constant header: funct3 defines F3_MUL..F3_REMU (000..111) and F7_MULDIV (0000001).
- Add to the shared struct package:
  - typedef enum muldiv_state_t {IDLE, CALC, FIX, DONE}
  - a muldiv_req_t struct {f3, a, b, rd}
- Add to the shared functions package: a get_expected_muldiv(f3, a, b) reference model for the bench.
- No sub-module; the datapath and FSM stay in muldiv_unit.

## Test plan
- MUL, a=7, b=0xFFFFFFFD → out_result 0xFFFFFFEB; out_valid first high in cycle 34; stall_req high in cycles 1–33.
- a=b=0xFFFFFFFF: MULHU → 0xFFFFFFFE; MULH → 0x00000000; MULHSU → 0xFFFFFFFF.
- DIV, a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. DIVU, a=7, b=2 → 3.
- Special cases, each with out_valid in cycle 1:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on the same operands → 0.
- Backpressure: hold out_ready low for 5 cycles in DONE → out_result, out_rd and out_valid stable; stall_req high; in_ready low.
- Kill paths:
  - Flush in cycle 10 of CALC → IDLE next cycle; no out_valid.
  - An immediately following MUL 3×4 → 12.
  - rst asserted mid-op → all outputs return to their reset values.
